vga_pattern_checker: RTL and testbench

VGA_PATTERN_CHECKER -- requirements
Module: vga_pattern_checker

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_pattern_checker_if.sv | 18 +
 rtl/vga_pattern_gen.sv | 40 ++++
 rtl/vga_pattern_checker.sv | 137 +++++++++++++
 tb/tb_vga_pattern_checker.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg : shared FSM states, pattern modes and default parameters for the
//           VGA pattern checker.                               Rev 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_PASS  = 2'd2;

  localparam int CW_DEF     = 8;
  localparam int IDX_W_DEF  = 6;
  localparam int STEP_DEF   = 4;
  localparam int ECNT_W_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/vga_pattern_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pattern_checker_if : observed pixel stream feeding the checker.
//                                                              Rev 1.0
// ---------------------------------------------------------------------------
interface vga_pattern_checker_if #(
  parameter int CW = 8
);
  logic          pixel_valid;
  logic          frame_start;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;

  modport master (output pixel_valid, frame_start, r, g, b);
  modport slave  (input  pixel_valid, frame_start, r, g, b);
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pattern_gen : combinational expected-colour generator for INC/CONST.
//                                                              Rev 1.0
// ---------------------------------------------------------------------------
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    seed,
  output logic [CW-1:0]    exp_r,
  output logic [CW-1:0]    exp_g,
  output logic [CW-1:0]    exp_b
);

  logic [CW-1:0] idx_ext;
  logic [CW-1:0] base;

  // All arithmetic is CW bits wide so the mod 2^CW wrap falls out naturally.
  assign idx_ext = CW'(idx);
  assign base    = idx_ext * CW'(STEP) + seed;

  always_comb begin
    exp_r = base;
    exp_g = base + 1'b1;
    exp_b = base + 2'd2;
    if (mode == MODE_CONST) begin
      exp_r = seed;
      exp_g = seed;
      exp_b = seed;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_pattern_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pattern_checker : compares a pixel stream against a generated pattern,
//                       counts pixels/mismatches, captures the first fault.
//                                                              Rev 1.0
// ---------------------------------------------------------------------------
module vga_pattern_checker
  import vga_pkg::*;
#(
  parameter int CW     = CW_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int STEP   = STEP_DEF,
  parameter int ECNT_W = ECNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     seed,
  input  logic              stop_on_err,
  input  logic              frame_start,
  input  logic              clear,
  input  logic              pixel_valid,
  input  logic [CW-1:0]     r,
  input  logic [CW-1:0]     g,
  input  logic [CW-1:0]     b,
  output logic              error,
  output logic [ECNT_W-1:0] error_count,
  output logic [31:0]       pixel_count,
  output logic [IDX_W-1:0]  first_idx,
  output logic [3*CW-1:0]   first_exp,
  output logic [3*CW-1:0]   first_act,
  output logic              busy
);

  localparam logic [ECNT_W-1:0] ECNT_MAX = {ECNT_W{1'b1}};

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              error_q;
  logic [ECNT_W-1:0] ecnt_q;
  logic [31:0]       pcnt_q;
  logic [IDX_W-1:0]  fidx_q;
  logic [3*CW-1:0]   fexp_q;
  logic [3*CW-1:0]   fact_q;

  logic [IDX_W-1:0]  idx_cur;
  logic [IDX_W-1:0]  idx_d;
  logic [CW-1:0]     exp_r;
  logic [CW-1:0]     exp_g;
  logic [CW-1:0]     exp_b;
  logic [3*CW-1:0]   exp_rgb;
  logic [3*CW-1:0]   act_rgb;
  logic              checking;
  logic              cmp_en;
  logic              mismatch;

  // frame_start rewinds the index for a pixel arriving in the same cycle.
  assign idx_cur  = frame_start ? '0 : idx_q;
  assign idx_d    = idx_cur + 1'b1;
  assign exp_rgb  = {exp_r, exp_g, exp_b};
  assign act_rgb  = {r, g, b};
  assign checking = (state_q == ST_CHECK) && pixel_valid && !clear;
  assign cmp_en   = (mode == MODE_INC) || (mode == MODE_CONST);
  assign mismatch = checking && cmp_en && (act_rgb != exp_rgb);

  vga_pattern_gen #(
    .CW    (CW),
    .IDX_W (IDX_W),
    .STEP  (STEP)
  ) u_gen (
    .idx   (idx_cur),
    .mode  (mode),
    .seed  (seed),
    .exp_r (exp_r),
    .exp_g (exp_g),
    .exp_b (exp_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      error_q <= 1'b0;
      ecnt_q  <= '0;
      pcnt_q  <= '0;
      fidx_q  <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
    end else begin
      if (clear) begin
        idx_q   <= '0;
        error_q <= 1'b0;
        ecnt_q  <= '0;
        pcnt_q  <= '0;
        fidx_q  <= '0;
        fexp_q  <= '0;
        fact_q  <= '0;
      end else begin
        if (frame_start) idx_q <= '0;
        if (checking) begin
          idx_q  <= idx_d;
          pcnt_q <= pcnt_q + 32'd1;
        end
        if (mismatch) begin
          error_q <= 1'b1;
          if (ecnt_q != ECNT_MAX) ecnt_q <= ecnt_q + 1'b1;
          if (!error_q) begin
            fidx_q <= idx_cur;
            fexp_q <= exp_rgb;
            fact_q <= act_rgb;
          end
        end
      end

      case (state_q)
        ST_IDLE:  if (enable) state_q <= ST_CHECK;
        ST_CHECK: begin
          if (!enable)                      state_q <= ST_IDLE;
          else if (mismatch && stop_on_err) state_q <= ST_HALT;
        end
        ST_HALT:  if (clear || !enable) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign error       = error_q;
  assign error_count = ecnt_q;
  assign pixel_count = pcnt_q;
  assign first_idx   = fidx_q;
  assign first_exp   = fexp_q;
  assign first_act   = fact_q;
  assign busy        = (state_q == ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_pattern_checker : directed stimulus with a queued scoreboard; a
//                          4-bit-counter twin exercises saturation.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_vga_pattern_checker;

  logic clk;
  logic reset_n;
  logic enable;
  logic [1:0] mode;
  logic [7:0] seed;
  logic stop_on_err;
  logic clear;

  vga_pattern_checker_if #(.CW(8)) px ();

  logic        error, error_s, busy, busy_s;
  logic [15:0] error_count;
  logic [3:0]  error_count_s;
  logic [31:0] pixel_count, pixel_count_s;
  logic [5:0]  first_idx, first_idx_s;
  logic [23:0] first_exp, first_exp_s, first_act, first_act_s;

  vga_pattern_checker dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .seed(seed),
    .stop_on_err(stop_on_err), .frame_start(px.frame_start), .clear(clear),
    .pixel_valid(px.pixel_valid), .r(px.r), .g(px.g), .b(px.b),
    .error(error), .error_count(error_count), .pixel_count(pixel_count),
    .first_idx(first_idx), .first_exp(first_exp), .first_act(first_act),
    .busy(busy)
  );

  vga_pattern_checker #(.ECNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .seed(seed),
    .stop_on_err(stop_on_err), .frame_start(px.frame_start), .clear(clear),
    .pixel_valid(px.pixel_valid), .r(px.r), .g(px.g), .b(px.b),
    .error(error_s), .error_count(error_count_s), .pixel_count(pixel_count_s),
    .first_idx(first_idx_s), .first_exp(first_exp_s), .first_act(first_act_s),
    .busy(busy_s)
  );

  typedef struct {
    string       tag;
    int          due;
    logic        err;
    int          ecnt;
    int          pcnt;
    logic [5:0]  fidx;
    logic [23:0] fexp;
    logic [23:0] fact;
    logic        bsy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic compare(input exp_t e);
    int sat;
    sat = (e.ecnt > 15) ? 15 : e.ecnt;
    chk({e.tag, ".error"},   64'(error),         64'(e.err));
    chk({e.tag, ".ecnt"},    64'(error_count),   64'(e.ecnt));
    chk({e.tag, ".ecnt4"},   64'(error_count_s), 64'(sat));
    chk({e.tag, ".pcnt"},    64'(pixel_count),   64'(e.pcnt));
    chk({e.tag, ".fidx"},    64'(first_idx),     64'(e.fidx));
    chk({e.tag, ".fexp"},    64'(first_exp),     64'(e.fexp));
    chk({e.tag, ".fact"},    64'(first_act),     64'(e.fact));
    chk({e.tag, ".busy"},    64'(busy),          64'(e.bsy));
  endtask

  // Monitor: drains every expectation whose due cycle has been reached.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        compare(e);
      end
    end
  end

  task automatic expect_now(input string tag, input logic err, input int ecnt,
                            input int pcnt, input logic [5:0] fidx,
                            input logic [23:0] fexp, input logic [23:0] fact,
                            input logic bsy);
    exp_t e;
    e.tag = tag; e.due = cyc; e.err = err; e.ecnt = ecnt; e.pcnt = pcnt;
    e.fidx = fidx; e.fexp = fexp; e.fact = fact; e.bsy = bsy;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                     input logic fs, input logic clr);
    px.r = rr; px.g = gg; px.b = bb;
    px.pixel_valid = 1'b1; px.frame_start = fs; clear = clr;
    @(posedge clk);
    #1;
    px.pixel_valid = 1'b0; px.frame_start = 1'b0; clear = 1'b0;
  endtask

  // Clean INC pixel for seed 0 at index k.
  task automatic inc_pix(input int k, input logic fs);
    logic [7:0] b8;
    b8 = 8'(k * 4);
    pix(b8, b8 + 8'd1, b8 + 8'd2, fs, 1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; mode = 2'd0; seed = 8'h00;
    stop_on_err = 1'b0; clear = 1'b0;
    px.pixel_valid = 1'b0; px.frame_start = 1'b0;
    px.r = '0; px.g = '0; px.b = '0;
    step(3);
    expect_now("reset", 0, 0, 0, 6'd0, 24'h0, 24'h0, 0);
    reset_n = 1'b1;
    step(1);
    expect_now("post_reset_idle", 0, 0, 0, 6'd0, 24'h0, 24'h0, 0);

    // Clean INC run across the 64-entry index wrap.
    enable = 1'b1;
    step(1);
    expect_now("enter_check", 0, 0, 0, 6'd0, 24'h0, 24'h0, 1);
    for (int i = 0; i < 70; i++) inc_pix(i % 64, 1'b0);
    expect_now("inc_clean70", 0, 0, 70, 6'd0, 24'h0, 24'h0, 1);

    // frame_start with a coincident pixel, then a single corrupt pixel.
    do_clear();
    expect_now("clear1", 0, 0, 0, 6'd0, 24'h0, 24'h0, 1);
    for (int i = 0; i < 3; i++) inc_pix(i, 1'b0);
    inc_pix(0, 1'b1);
    expect_now("fs_with_pixel", 0, 0, 4, 6'd0, 24'h0, 24'h0, 1);
    for (int i = 1; i < 5; i++) inc_pix(i, 1'b0);
    pix(8'h14, 8'h00, 8'h16, 1'b0, 1'b0);
    expect_now("corrupt_idx5", 1, 1, 9, 6'd5, 24'h141516, 24'h140016, 1);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_now("second_err_keeps_first", 1, 2, 10, 6'd5, 24'h141516, 24'h140016, 1);
    pix(8'h00, 8'h01, 8'h02, 1'b0, 1'b1);
    expect_now("clear_with_pixel", 0, 0, 0, 6'd0, 24'h0, 24'h0, 1);

    // stop_on_err: halt at idx 3, ignore idx 4, clear back to IDLE.
    stop_on_err = 1'b1;
    for (int i = 0; i < 3; i++) inc_pix(i, 1'b0);
    pix(8'h00, 8'h0d, 8'h0e, 1'b0, 1'b0);
    expect_now("halt_idx3", 1, 1, 4, 6'd3, 24'h0c0d0e, 24'h000d0e, 0);
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_now("halt_ignores", 1, 1, 4, 6'd3, 24'h0c0d0e, 24'h000d0e, 0);
    do_clear();
    expect_now("halt_clear", 0, 0, 0, 6'd0, 24'h0, 24'h0, 0);
    stop_on_err = 1'b0;
    step(1);
    expect_now("recheck", 0, 0, 0, 6'd0, 24'h0, 24'h0, 1);

    // CONST mode, then PASS and reserved modes never flag.
    mode = 2'd1; seed = 8'hA5;
    for (int i = 0; i < 5; i++) pix(8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0);
    expect_now("const_clean", 0, 0, 5, 6'd0, 24'h0, 24'h0, 1);
    pix(8'hA4, 8'hA5, 8'hA5, 1'b0, 1'b0);
    expect_now("const_err", 1, 1, 6, 6'd5, 24'hA5A5A5, 24'hA4A5A5, 1);
    mode = 2'd2;
    pix(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
    expect_now("pass_mode", 1, 1, 7, 6'd5, 24'hA5A5A5, 24'hA4A5A5, 1);
    mode = 2'd3;
    pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_now("reserved_mode", 1, 1, 8, 6'd5, 24'hA5A5A5, 24'hA4A5A5, 1);

    // Saturation of the 4-bit twin after 20 mismatches.
    mode = 2'd0; seed = 8'h00;
    do_clear();
    expect_now("clear2", 0, 0, 0, 6'd0, 24'h0, 24'h0, 1);
    for (int i = 0; i < 20; i++) pix(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    expect_now("twenty_errs", 1, 20, 20, 6'd0, 24'h000102, 24'h000000, 1);

    // Disable keeps results and idx; re-enable continues at idx 20.
    enable = 1'b0;
    step(1);
    expect_now("disabled", 1, 20, 20, 6'd0, 24'h000102, 24'h000000, 0);
    pix(8'h50, 8'h51, 8'h52, 1'b0, 1'b0);
    expect_now("idle_ignores", 1, 20, 20, 6'd0, 24'h000102, 24'h000000, 0);
    enable = 1'b1;
    step(1);
    pix(8'h50, 8'h51, 8'h52, 1'b0, 1'b0);
    expect_now("resume_idx20", 1, 20, 21, 6'd0, 24'h000102, 24'h000000, 1);
    step(1);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst.error", 64'(error), 64'(0));
    chk("async_rst.ecnt",  64'(error_count), 64'(0));
    chk("async_rst.ecnt4", 64'(error_count_s), 64'(0));
    chk("async_rst.pcnt",  64'(pixel_count), 64'(0));
    chk("async_rst.fexp",  64'(first_exp), 64'(0));
    chk("async_rst.busy",  64'(busy), 64'(0));
    step(1);
    reset_n = 1'b1;
    step(1);
    inc_pix(0, 1'b0);
    expect_now("after_reset_idx0", 0, 0, 1, 6'd0, 24'h0, 24'h0, 1);

    step(2);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
